reservoir_step_scheduler: RTL and testbench

//  Sequences one reservoir time step of the integer echo state network.

---
 rtl/reservoir_step_scheduler_if.sv | 31 +++
 rtl/reservoir_step_scheduler.sv | 125 ++++++++++++
 tb/tb_reservoir_step_scheduler.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reservoir_step_scheduler_if.sv
// Handshake and cell-drive bundle between a step source and the reservoir
// step scheduler. The master side supplies input vectors and the hold
// request; the slave side (the scheduler) drives the per-cell enables and
// status.
interface reservoir_step_scheduler_if #(
    parameter int NUM_CELLS = 16,
    parameter int IDX_W     = 4,
    parameter int STEP_W    = 8
);
    logic                 iValid;
    logic                 oReady;
    logic [NUM_CELLS-1:0] iU;
    logic                 iHold;
    logic [NUM_CELLS-1:0] oCellEn;
    logic                 oBitU;
    logic [IDX_W-1:0]     oCellIdx;
    logic                 oBusy;
    logic                 oStepDone;
    logic [STEP_W-1:0]    oStepCnt;
    logic                 oWashout;

    modport master (
        output iValid, iU, iHold,
        input  oReady, oCellEn, oBitU, oCellIdx, oBusy, oStepDone, oStepCnt, oWashout
    );

    modport slave (
        input  iValid, iU, iHold,
        output oReady, oCellEn, oBitU, oCellIdx, oBusy, oStepDone, oStepCnt, oWashout
    );
endinterface

// File: rtl/reservoir_step_scheduler.sv
// Reservoir step scheduler: latches one input sign vector, then enables the
// reservoir cells one at a time in ascending order, presenting each cell's
// +1/-1 bit on the shared bit line. After an optional settle gap it pulses
// step-done, counts completed steps and tracks the washout phase.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for a new input vector
// S_UPDATE | walking cells 0..NUM_CELLS-1, one enable per unstalled cycle
// S_SETTLE | waiting SETTLE_CYC cycles for the cell counters to settle
// S_DONE   | one-cycle step-done pulse, step and washout counters advance
module reservoir_step_scheduler #(
    parameter int NUM_CELLS  = 16,
    parameter int IDX_W      = 4,
    parameter int SETTLE_CYC = 2,
    parameter int STEP_W     = 8,
    parameter int WASHOUT    = 4
) (
    input  logic                        iClk,
    input  logic                        iRst_n,
    reservoir_step_scheduler_if.slave   bus
);

    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int WASH_W = (WASHOUT > 0) ? $clog2(WASHOUT + 1) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CELLS - 1);
    localparam logic [SET_W-1:0]  SET_LOAD = (SETTLE_CYC > 0) ? SET_W'(SETTLE_CYC - 1) : '0;
    localparam logic [WASH_W-1:0] WASH_MAX = WASH_W'(WASHOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state_q;
    logic [NUM_CELLS-1:0] u_q;
    logic [IDX_W-1:0]     idx_q;
    logic [SET_W-1:0]     settle_q;
    logic [STEP_W-1:0]    step_q;
    logic [WASH_W-1:0]    wash_q;

    logic [NUM_CELLS-1:0] cell_en_d;
    logic                 bit_u_d;

    // Step sequencer: vector capture, cell walk, settle down-counter, step bookkeeping.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= S_IDLE;
            u_q      <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            step_q   <= '0;
            wash_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.iValid) begin
                        u_q     <= bus.iU;
                        idx_q   <= '0;
                        state_q <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (!bus.iHold) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (SETTLE_CYC > 0) begin
                                settle_q <= SET_LOAD;
                                state_q  <= S_SETTLE;
                            end else begin
                                state_q  <= S_DONE;
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    // Hold requests only stall the cell walk; settling always runs to completion.
                    if (settle_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                S_DONE: begin
                    step_q <= step_q + STEP_W'(1);
                    // Saturates so the washout flag never returns once the step count wraps.
                    if (wash_q != WASH_MAX) begin
                        wash_q <= wash_q + WASH_W'(1);
                    end
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Cell drive: one-hot enable and the addressed cell's sign bit, gated off by hold.
    always_comb begin
        cell_en_d = '0;
        bit_u_d   = 1'b0;
        if (state_q == S_UPDATE) begin
            bit_u_d = u_q[idx_q];
            if (!bus.iHold) begin
                cell_en_d = NUM_CELLS'(1) << idx_q;
            end
        end
    end

    assign bus.oCellEn   = cell_en_d;
    assign bus.oBitU     = bit_u_d;
    assign bus.oReady    = (state_q == S_IDLE);
    assign bus.oBusy     = (state_q != S_IDLE);
    assign bus.oStepDone = (state_q == S_DONE);
    assign bus.oCellIdx  = idx_q;
    assign bus.oStepCnt  = step_q;
    assign bus.oWashout  = (wash_q != WASH_MAX);

endmodule

// File: tb/tb_reservoir_step_scheduler.sv
// Bench for reservoir_step_scheduler: a queue of expected (index, bit) cell
// enables is loaded at each accepted vector and drained as enables appear.
// A second instance with a 3-bit step counter shares the stimulus to cover
// step-count wrap.
module tb_reservoir_step_scheduler;

    localparam int N      = 16;
    localparam int IDXW   = 4;
    localparam int SETTLE = 2;
    localparam int WASH   = 4;

    typedef struct {
        int   idx;
        logic b;
    } cell_exp_t;

    logic iClk;
    logic iRst_n;

    reservoir_step_scheduler_if #(.NUM_CELLS(N), .IDX_W(IDXW), .STEP_W(8)) if1 ();
    reservoir_step_scheduler_if #(.NUM_CELLS(N), .IDX_W(IDXW), .STEP_W(3)) if2 ();

    assign if2.iValid = if1.iValid;
    assign if2.iU     = if1.iU;
    assign if2.iHold  = if1.iHold;

    reservoir_step_scheduler #(
        .NUM_CELLS(N), .IDX_W(IDXW), .SETTLE_CYC(SETTLE), .STEP_W(8), .WASHOUT(WASH)
    ) dut (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .bus   (if1.slave)
    );

    reservoir_step_scheduler #(
        .NUM_CELLS(N), .IDX_W(IDXW), .SETTLE_CYC(SETTLE), .STEP_W(3), .WASHOUT(WASH)
    ) dut_w3 (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .bus   (if2.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    cell_exp_t exp_q[$];
    int   cyc       = 0;
    int   hs_cyc    = 0;
    int   holds     = 0;
    int   en_seen   = 0;
    int   exp_steps = 0;
    logic in_step   = 1'b0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor / scoreboard on the falling edge.
    always @(negedge iClk) begin
        if (iRst_n) begin
            chk("ready", 32'(if1.oReady), 32'(!in_step));
            chk("busy", 32'(if1.oBusy), 32'(in_step));
            chk("step_cnt", 32'(if1.oStepCnt), 32'(exp_steps % 256));
            chk("washout", 32'(if1.oWashout), 32'(exp_steps < WASH));
            chk("step_cnt_w3", 32'(if2.oStepCnt), 32'(exp_steps % 8));
            chk("washout_w3", 32'(if2.oWashout), 32'(exp_steps < WASH));
            if (if1.iHold && in_step && en_seen < N) begin
                holds++;
                chk("hold_en", 32'(if1.oCellEn), 32'd0);
            end
            if (if1.oCellEn != '0) begin
                if (exp_q.size() == 0) begin
                    chk("extra_en", 32'(if1.oCellEn), 32'd0);
                end else begin
                    cell_exp_t e;
                    e = exp_q.pop_front();
                    chk("cell_en", 32'(if1.oCellEn), 32'(1) << e.idx);
                    chk("cell_idx", 32'(if1.oCellIdx), 32'(e.idx));
                    chk("bit_u", 32'(if1.oBitU), 32'(e.b));
                    chk("cell_en_w3", 32'(if2.oCellEn), 32'(1) << e.idx);
                    en_seen++;
                end
            end
            if (if1.oStepDone) begin
                chk("done_in_step", 32'(in_step), 32'd1);
                chk("done_lat", 32'(cyc - hs_cyc), 32'(N + 1 + SETTLE + holds));
                chk("en_count", 32'(en_seen), 32'(N));
                chk("done_w3", 32'(if2.oStepDone), 32'd1);
                in_step = 1'b0;
                exp_steps++;
            end
            if (if1.iValid && if1.oReady) begin
                for (int k = 0; k < N; k++) begin
                    cell_exp_t e;
                    e.idx = k;
                    e.b   = if1.iU[k];
                    exp_q.push_back(e);
                end
                hs_cyc  = cyc;
                holds   = 0;
                en_seen = 0;
                in_step = 1'b1;
            end
        end
    end

    task automatic wait_accept();
        bit ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge iClk);
            if (if1.oReady) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'(if1.oReady), 32'd1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge iClk);
            if (if1.oStepDone) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'(if1.oStepDone), 32'd1);
    endtask

    task automatic run_step(input logic [N-1:0] vec, input int hold_at, input int hold_len);
        @(posedge iClk); #1;
        if1.iValid = 1'b1;
        if1.iU     = vec;
        wait_accept();
        @(posedge iClk); #1;
        if1.iValid = 1'b0;
        if1.iU     = ~vec;
        if (hold_len > 0) begin
            for (int k = 0; k < 100; k++) begin
                if (int'(if1.oCellIdx) == hold_at) break;
                @(posedge iClk); #1;
            end
            if1.iHold = 1'b1;
            for (int h = 0; h < hold_len; h++) begin
                @(negedge iClk);
                chk("hold_idx", 32'(if1.oCellIdx), 32'(hold_at));
                @(posedge iClk);
            end
            #1 if1.iHold = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        int dones;
        bit found;
        if1.iValid = 1'b0;
        if1.iU     = '0;
        if1.iHold  = 1'b0;
        iRst_n     = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_ready", 32'(if1.oReady), 32'd1);
        chk("rst_busy", 32'(if1.oBusy), 32'd0);
        chk("rst_en", 32'(if1.oCellEn), 32'd0);
        chk("rst_bitu", 32'(if1.oBitU), 32'd0);
        chk("rst_idx", 32'(if1.oCellIdx), 32'd0);
        chk("rst_done", 32'(if1.oStepDone), 32'd0);
        chk("rst_cnt", 32'(if1.oStepCnt), 32'd0);
        chk("rst_wash", 32'(if1.oWashout), 32'd1);
        iRst_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            @(negedge iClk);
            chk("idle_ready", 32'(if1.oReady), 32'd1);
            chk("idle_en", 32'(if1.oCellEn), 32'd0);
            chk("idle_done", 32'(if1.oStepDone), 32'd0);
            chk("idle_wash", 32'(if1.oWashout), 32'd1);
        end

        run_step(16'hA5C3, -1, 0);
        run_step(16'h3C96, 5, 3);

        // Valid held high across a busy step with iU changing every cycle.
        @(posedge iClk); #1;
        if1.iValid = 1'b1;
        if1.iU     = 16'h1234;
        dones = 0;
        for (int k = 0; k < 200 && dones < 2; k++) begin
            @(negedge iClk);
            if (if1.oStepDone) dones++;
            if (dones < 2) begin
                @(posedge iClk); #1;
                if1.iU = N'($urandom);
            end
        end
        if (dones < 2) chk("b2b_timeout", 32'(dones), 32'd2);
        @(posedge iClk); #1;
        if1.iValid = 1'b0;

        for (int s = 0; s < 6; s++) begin
            run_step(N'($urandom), -1, 0);
        end

        // Asynchronous reset in the middle of a step.
        @(posedge iClk); #1;
        if1.iValid = 1'b1;
        if1.iU     = 16'hFFFF;
        wait_accept();
        @(posedge iClk); #1;
        if1.iValid = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge iClk);
            if (if1.oCellIdx == 4'd7) begin
                found = 1;
                break;
            end
        end
        if (!found) chk("idx7_timeout", 32'(if1.oCellIdx), 32'd7);
        #1 iRst_n = 1'b0;
        #1;
        chk("arst_en", 32'(if1.oCellEn), 32'd0);
        chk("arst_busy", 32'(if1.oBusy), 32'd0);
        chk("arst_cnt", 32'(if1.oStepCnt), 32'd0);
        chk("arst_ready", 32'(if1.oReady), 32'd1);
        chk("arst_idx", 32'(if1.oCellIdx), 32'd0);
        chk("arst_wash", 32'(if1.oWashout), 32'd1);
        exp_q.delete();
        exp_steps = 0;
        in_step   = 1'b0;
        @(posedge iClk); #1;
        iRst_n = 1'b1;

        run_step(16'h8001, -1, 0);
        @(negedge iClk);
        chk("final_cnt", 32'(if1.oStepCnt), 32'd1);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
